instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL run on one clock with a synchronous, active-high reset.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_valid  input  1  imem_data valid for the outstanding request.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 inst  output  32  issued instruction.
REQ-010 opcode  output  6  inst[31:26], to the control unit.
REQ-011 func  output  6  inst[5:0], to the control unit.
REQ-012 inst_valid  output  1  inst/opcode/func valid.
REQ-013 inst_ack  input  1  datapath retires the issued instruction; the redirect inputs are sampled in this cycle.
REQ-014 Jump, JumpReg, Branch  input  1 each  control-unit redirect signals.
REQ-015 zero  input  1  ALU zero flag; a branch is taken when Branch=1 and zero=1.
REQ-016 rs_data  input  32  register value for JumpReg.
REQ-017 pc_out  output  32  address of the issued instruction.
REQ-018 link_addr  output  32  return address for Link writes.
REQ-019 halted  output  1  syscall retired; fetching has stopped.

Function
REQ-020 States SHALL be IDLE, FETCH, ISSUE and HALT.
- IDLE->FETCH unconditionally.
- FETCH->ISSUE on imem_valid.
- ISSUE->FETCH on inst_ack.
- ISSUE->HALT on inst_ack of a syscall (opcode 0, func 6'h0C).
- HALT is left only by reset.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC, both held stable until imem_valid; imem_req SHALL be 0 in every other state.
REQ-022 imem_valid outside FETCH SHALL be ignored.
REQ-023 imem_data SHALL be registered: imem_valid in cycle N gives inst_valid=1 in cycle N+1; a full instruction takes 2 cycles minimum.
REQ-024 inst, opcode, func, pc_out and link_addr SHALL hold stable while inst_valid=1; inst_ack while inst_valid=0 SHALL be ignored.
REQ-025 On inst_ack, the next PC SHALL be selected by priority:
- JumpReg: {rs_data[31:2],2'b00}.
- Jump: {pc_plus4[31:28],inst[25:0],2'b00}.
- Branch&zero: pc_plus4 + (sign-extended inst[15:0] << 2).
- Otherwise pc_plus4.
All additions wrap modulo 2^32.
REQ-026 pc_plus4 SHALL be pc_out+4, wrapping at 32'hFFFF_FFFC to 0.

Reset
REQ-027 Reset SHALL force state=IDLE, PC=RESET_PC, imem_req=0, inst_valid=0, halted=0, inst=0, pc_out=RESET_PC, and clear any pending delay-slot target.
REQ-028 Reset asserted mid-fetch or mid-issue SHALL abort the operation; imem_valid coincident with reset SHALL be discarded.
REQ-029 The first cycle after reset deasserts SHALL be IDLE; the next cycle SHALL be FETCH with imem_addr=RESET_PC.

Configuration
REQ-030 Macro BRANCH_DELAY_SLOT_EN SHALL select delay-slot behaviour.
REQ-031 When defined:
- A taken redirect SHALL store its target and fetch pc_plus4 (the delay slot) next.
- After the delay slot is acked, the PC SHALL become the stored target.
- Redirects from the delay-slot instruction SHALL be ignored.
- link_addr SHALL be pc_out+8.
REQ-032 When undefined:
- A taken redirect SHALL load the PC directly, with no slot.
- link_addr SHALL be pc_out+4.

Verification
REQ-033 Reset with RESET_PC=32'h0000_0100: after reset drops, imem_req=0 for 1 cycle, then imem_req=1 with imem_addr=32'h100.
REQ-034 imem_valid delayed 3 cycles: imem_addr is held at 32'h100 throughout; inst_valid=1 the cycle after imem_valid; opcode and func match imem_data.
REQ-035 Fetch 32'h1000_FFFF (beq, imm=-1) at pc=32'h200 with Branch=1, zero=1:
- Without the macro, the next imem_addr is 32'h200.
- With the macro, the fetch sequence is 32'h204 then 32'h200.
REQ-036 JumpReg=1 with rs_data=32'h0000_1237: next imem_addr=32'h1234; Jump=1 asserted in the same cycle is ignored.
REQ-037 Syscall 32'h0000_000C acked: halted=1 and imem_req stays 0 for 10 cycles; after reset, halted=0.
REQ-038 Sequential fetch at pc=32'hFFFF_FFFC with no redirect: next imem_addr=32'h0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/ISSUE/HALT sequencer with PC redirect logic.
// Define BRANCH_DELAY_SLOT_EN to execute one delay-slot instruction after each taken redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        inst_valid,
  input  logic        inst_ack,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        Branch,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_out,
  output logic [31:0] link_addr,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
`ifdef BRANCH_DELAY_SLOT_EN
  logic        slot_q, slot_d;
  logic [31:0] tgt_q, tgt_d;
`endif

  logic        is_syscall;
  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] redir_tgt;

  assign is_syscall = (inst_q[31:26] == 6'h00) && (inst_q[5:0] == 6'h0C);
  assign pc_plus4   = pc_out_q + 32'd4;
  assign br_off     = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= 32'h0;
      pc_out_q <= RESET_PC;
`ifdef BRANCH_DELAY_SLOT_EN
      slot_q   <= 1'b0;
      tgt_q    <= 32'h0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
`ifdef BRANCH_DELAY_SLOT_EN
      slot_q   <= slot_d;
      tgt_q    <= tgt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_valid) state_d = ISSUE;
      ISSUE:   if (inst_ack) state_d = is_syscall ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == FETCH);
    inst_valid = (state_q == ISSUE);
    halted     = (state_q == HALT);
  end

  // Redirect priority: JumpReg, then Jump, then taken branch.
  always_comb begin
    taken = JumpReg | Jump | (Branch & zero);
    if (JumpReg)   redir_tgt = rs_data & 32'hFFFF_FFFC;
    else if (Jump) redir_tgt = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    else           redir_tgt = pc_plus4 + br_off;
  end

  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
`ifdef BRANCH_DELAY_SLOT_EN
    slot_d   = slot_q;
    tgt_d    = tgt_q;
`endif
    if (state_q == FETCH && imem_valid) begin
      inst_d   = imem_data;
      pc_out_d = pc_q;
    end
    if (state_q == ISSUE && inst_ack) begin
`ifdef BRANCH_DELAY_SLOT_EN
      // The slot instruction's own redirect inputs are ignored.
      if (slot_q) begin
        pc_d   = tgt_q;
        slot_d = 1'b0;
      end else if (taken) begin
        tgt_d  = redir_tgt;
        slot_d = 1'b1;
        pc_d   = pc_plus4;
      end else begin
        pc_d   = pc_plus4;
      end
`else
      pc_d = taken ? redir_tgt : pc_plus4;
`endif
    end
  end

  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign opcode    = inst_q[31:26];
  assign func      = inst_q[5:0];
  assign pc_out    = pc_out_q;
`ifdef BRANCH_DELAY_SLOT_EN
  assign link_addr = pc_out_q + 32'd8;
`else
  assign link_addr = pc_out_q + 32'd4;
`endif

endmodule
